// File: rtl/exception_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exception_sequencer_pkg
// Purpose  : Shared control definitions for the exception sequencer:
//            PC-source mux codes, cause codes, FSM state encoding and the
//            default handler-pointer vector addresses.
// Revision : 1.0 - initial release
// ============================================================================
package exception_sequencer_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_JUMP = 2'd2
  } state_t;

  // PC-source multiplexer select codes
  localparam logic [2:0] C_PCSRC_JUMP   = 3'b000;
  localparam logic [2:0] C_PCSRC_EPC    = 3'b001;
  localparam logic [2:0] C_PCSRC_RESULT = 3'b010;
  localparam logic [2:0] C_PCSRC_ALUOUT = 3'b011;

  // Exception cause codes
  localparam logic [1:0] C_CAUSE_NONE   = 2'b00;
  localparam logic [1:0] C_CAUSE_OPCODE = 2'b01;
  localparam logic [1:0] C_CAUSE_OVF    = 2'b10;
  localparam logic [1:0] C_CAUSE_DIV0   = 2'b11;

  // Default byte addresses of the handler pointers
  localparam logic [31:0] C_VEC_OPC_DEFAULT = 32'd253;
  localparam logic [31:0] C_VEC_OVF_DEFAULT = 32'd254;
  localparam logic [31:0] C_VEC_DIV_DEFAULT = 32'd255;

  // Priority-encode the exception flags: opcode > div0 > overflow
  function automatic logic [1:0] encode_cause(input logic opc,
                                               input logic ovf,
                                               input logic div0);
    logic [1:0] c;
    c = C_CAUSE_NONE;
    if (opc)       c = C_CAUSE_OPCODE;
    else if (div0) c = C_CAUSE_DIV0;
    else if (ovf)  c = C_CAUSE_OVF;
    return c;
  endfunction

endpackage : exception_sequencer_pkg
`default_nettype wire

// File: rtl/exception_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exception_sequencer
// Purpose  : Multicycle sequencer for invalid-opcode, overflow and
//            divide-by-zero exceptions plus the return-from-exception path.
//            Saves EPC, fetches the handler pointer from memory and
//            redirects the PC through the PC-source multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter logic [31:0] VEC_OPC = C_VEC_OPC_DEFAULT,
  parameter logic [31:0] VEC_OVF = C_VEC_OVF_DEFAULT,
  parameter logic [31:0] VEC_DIV = C_VEC_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic        rte,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] epc,
  output logic [31:0] handler_addr,
  output logic [2:0]  pc_source,
  output logic        pc_write,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        done
);

  // Counter just wide enough to hold MEM_LAT-1
  localparam int unsigned      CNT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      handler_q, handler_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       cause_q, cause_d;
  logic             w_any_exc;
  logic [31:0]      w_vec;
  logic             w_unused_data_hi;

  // Only the low byte of the fetched pointer is meaningful
  assign w_unused_data_hi = ^mem_data_in[31:8];

  assign w_any_exc = exc_opcode | exc_ovf | exc_div0;

  // Vector selection follows the same priority as the cause encoder
  always_comb begin
    w_vec = VEC_OVF;
    if (exc_opcode)    w_vec = VEC_OPC;
    else if (exc_div0) w_vec = VEC_DIV;
  end

  // Next-state logic and strobe generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    epc_d     = epc_q;
    handler_d = handler_q;
    addr_d    = addr_q;
    cause_d   = cause_q;
    pc_source = C_PCSRC_JUMP;
    pc_write  = 1'b0;
    mem_rd    = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_any_exc) begin
          // Exception wins over a simultaneous rte
          epc_d   = pc_in - 32'd4;
          cause_d = encode_cause(exc_opcode, exc_ovf, exc_div0);
          addr_d  = w_vec;
          cnt_d   = C_CNT_LOAD;
          state_d = ST_READ;
        end else if (rte) begin
          // Zero-latency return: PC loads from EPC at the end of this cycle
          pc_source = C_PCSRC_EPC;
          pc_write  = 1'b1;
        end
      end
      ST_READ: begin
        mem_rd = 1'b1;
        if (cnt_q == '0) begin
          handler_d = {24'b0, mem_data_in[7:0]};
          state_d   = ST_JUMP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_JUMP: begin
        pc_source = C_PCSRC_RESULT;
        pc_write  = 1'b1;
        done      = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // No strobe may escape while reset is being applied
    if (reset) begin
      pc_source = C_PCSRC_JUMP;
      pc_write  = 1'b0;
      mem_rd    = 1'b0;
      done      = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      epc_q     <= '0;
      handler_q <= '0;
      addr_q    <= '0;
      cause_q   <= C_CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      epc_q     <= epc_d;
      handler_q <= handler_d;
      addr_q    <= addr_d;
      cause_q   <= cause_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign epc          = epc_q;
  assign handler_addr = handler_q;
  assign mem_addr     = addr_q;
  assign cause        = cause_q;

endmodule : exception_sequencer
`default_nettype wire

// File: tb/tb_exception_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exception_sequencer
// Purpose  : Self-checking bench for exception_sequencer. Two instances
//            (memory latency 1 and 3) share the same stimulus; each has a
//            latency-accurate memory, a transaction-level reference model
//            and a scoreboard popped by a monitor on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exception_sequencer;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        exc_opcode = 1'b0;
  logic        exc_ovf    = 1'b0;
  logic        exc_div0   = 1'b0;
  logic        rte        = 1'b0;
  logic [31:0] pc_in      = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] mem [256];

  typedef struct {
    logic [31:0] epc;
    logic [31:0] addr;
    logic [31:0] hdl;
    logic [1:0]  cause;
    int          done_cyc;
  } exp_t;

  // Clock
  always #5 clk = ~clk;

  // Cycle index: value seen after an edge names the cycle that edge starts
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int lat,
                     input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s lat=%0d cyc=%0d actual=%h required=%h",
               name, lat, cyc, act, req);
    end
  endtask

  // Reference rules: cause code and vector from the exception flags
  function automatic logic [1:0] ref_cause(input logic o, input logic v, input logic d);
    if (o) return 2'b01;
    if (d) return 2'b11;
    if (v) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_vec(input logic o, input logic d);
    if (o) return 32'd253;
    if (d) return 32'd255;
    return 32'd254;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic        mem_rd, pc_write, busy, done;
    logic [31:0] mem_addr, epc, handler_addr, mem_data_in;
    logic [2:0]  pc_source;
    logic [1:0]  cause;
    int          rdcnt;

    exception_sequencer #(
      .MEM_LAT (LAT),
      .VEC_OPC (32'd253),
      .VEC_OVF (32'd254),
      .VEC_DIV (32'd255)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .exc_opcode   (exc_opcode),
      .exc_ovf      (exc_ovf),
      .exc_div0     (exc_div0),
      .rte          (rte),
      .pc_in        (pc_in),
      .mem_data_in  (mem_data_in),
      .mem_rd       (mem_rd),
      .mem_addr     (mem_addr),
      .epc          (epc),
      .handler_addr (handler_addr),
      .pc_source    (pc_source),
      .pc_write     (pc_write),
      .cause        (cause),
      .busy         (busy),
      .done         (done)
    );

    // Memory: data is valid only in the LAT-th cycle of a read, garbage before
    always @(posedge clk) begin
      if (reset || !mem_rd) rdcnt <= 0;
      else                  rdcnt <= rdcnt + 1;
    end
    assign mem_data_in = (mem_rd && rdcnt == LAT - 1) ? mem[mem_addr[7:0]]
                                                      : ~mem[mem_addr[7:0]];

    // Reference model state
    int          acc_c   = -100;
    int          free_at = 0;
    int          h_at    = -100;
    logic [31:0] m_epc   = 32'd0;
    logic [31:0] m_addr  = 32'd0;
    logic [31:0] m_hdl   = 32'd0;
    logic [31:0] h_val   = 32'd0;
    logic [1:0]  m_cause = 2'd0;
    exp_t        sb [$];
    exp_t        e_push, e_pop;
    logic        busy_e, rd_e, jump_e, rte_e, pcw_e;
    logic [2:0]  pcs_e;

    // Model: evaluates the inputs of the cycle that this edge ends
    always @(posedge clk) begin
      if (reset) begin
        m_epc = 0; m_addr = 0; m_hdl = 0; m_cause = 0;
        sb.delete();
        acc_c   = -100;
        h_at    = -100;
        free_at = cyc + 1;
      end else begin
        if (cyc == h_at) m_hdl = h_val;
        if (cyc >= free_at && (exc_opcode || exc_ovf || exc_div0)) begin
          m_epc   = pc_in - 32'd4;
          m_cause = ref_cause(exc_opcode, exc_ovf, exc_div0);
          m_addr  = ref_vec(exc_opcode, exc_div0);
          h_val   = {24'b0, mem[m_addr[7:0]][7:0]};
          h_at    = cyc + LAT;
          acc_c   = cyc;
          free_at = cyc + LAT + 2;
          e_push.epc      = m_epc;
          e_push.addr     = m_addr;
          e_push.hdl      = h_val;
          e_push.cause    = m_cause;
          e_push.done_cyc = cyc + LAT + 1;
          sb.push_back(e_push);
        end
      end
    end

    // Monitor: compares mid-cycle, skipping cycles where reset is applied
    always @(negedge clk) begin
      if (!reset) begin
        busy_e = (cyc >= acc_c + 1) && (cyc <= acc_c + LAT + 1);
        rd_e   = (cyc >= acc_c + 1) && (cyc <= acc_c + LAT);
        jump_e = (cyc == acc_c + LAT + 1);
        rte_e  = !busy_e && rte && !(exc_opcode || exc_ovf || exc_div0);
        pcw_e  = jump_e || rte_e;
        pcs_e  = jump_e ? 3'b010 : (rte_e ? 3'b001 : 3'b000);

        if (sb.size() > 0 && sb[0].done_cyc == cyc) begin
          e_pop = sb.pop_front();
          chk("done_pulse",  LAT, 32'(done),   32'd1);
          chk("done_pcsrc",  LAT, 32'(pc_source), 32'd2);
          chk("done_hdl",    LAT, handler_addr, e_pop.hdl);
          chk("done_epc",    LAT, epc,          e_pop.epc);
          chk("done_cause",  LAT, 32'(cause),   32'(e_pop.cause));
          chk("done_addr",   LAT, mem_addr,     e_pop.addr);
        end else begin
          chk("no_done",     LAT, 32'(done),   32'd0);
        end

        chk("busy",      LAT, 32'(busy),      32'(busy_e));
        chk("mem_rd",    LAT, 32'(mem_rd),    32'(rd_e));
        chk("pc_write",  LAT, 32'(pc_write),  32'(pcw_e));
        chk("pc_source", LAT, 32'(pc_source), 32'(pcs_e));
        chk("epc",       LAT, epc,            m_epc);
        chk("cause",     LAT, 32'(cause),     32'(m_cause));
        chk("mem_addr",  LAT, mem_addr,       m_addr);
        chk("handler",   LAT, handler_addr,   m_hdl);
      end
    end
  end

  // Apply one cycle of inputs, then advance to just after the next edge
  task automatic drive(input logic rs, input logic o, input logic v,
                       input logic d, input logic r, input logic [31:0] pc);
    reset      = rs;
    exc_opcode = o;
    exc_ovf    = v;
    exc_div0   = d;
    rte        = r;
    pc_in      = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000);
  endtask

  // Stimulus
  initial begin
    logic        r_rs, r_o, r_v, r_d, r_r;
    logic [31:0] r_pc;

    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    mem[253] = 32'hFFFF_FF80;
    mem[254] = 32'h1234_5640;
    mem[255] = 32'hCAFE_BA11;

    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(2);

    // Overflow with pc_in = 0x108
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0108);
    idle(6);
    // Return from exception with epc = 0x104
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2000);
    idle(2);
    // Opcode and div0 together
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200);
    idle(6);
    // div0, then div0 during READ, then rte one cycle later
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0300);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0400);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0404);
    idle(6);
    // Exception and rte together
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0600);
    idle(6);
    // Wrap-around of pc_in - 4
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
    idle(6);
    // Reset in the second cycle after acceptance, then a normal exception
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0700);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0500);
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r_rs = ($urandom_range(99) == 0);
      r_o  = ($urandom_range(7) == 0);
      r_v  = ($urandom_range(7) == 0);
      r_d  = ($urandom_range(7) == 0);
      r_r  = ($urandom_range(5) == 0);
      r_pc = ($urandom_range(3) == 0) ? 32'($urandom_range(8)) : $urandom;
      drive(r_rs, r_o, r_v, r_d, r_r, r_pc);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_exception_sequencer
`default_nettype wire
